// File: rtl/cache_pkg.sv
// Shared widths, helpers and FSM state encoding for the cache memory side.
package cache_pkg;

  localparam int unsigned ADR_WIDTH      = 32;
  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned WORDS_PER_LINE = 4;

  // Index width for n entries, never narrower than one bit
  function automatic int unsigned beat_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned BEAT_W     = beat_w(WORDS_PER_LINE);
  localparam int unsigned LINE_OFS_W = BEAT_W + 2;

  typedef enum logic [2:0] {
    IDLE,
    WBURST,
    WAIT,
    RBURST,
    WACK
  } state_e;

endpackage

// File: rtl/cache_mem_array.sv
// Word storage for the memory responder: synchronous write, combinational read.
// Each word powers up holding its own byte offset; it is never reset.
module cache_mem_array #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = cache_pkg::beat_w(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         wr_adr_i,
  input  logic [DATA_WIDTH-1:0] wr_dat_i,
  input  logic [AW-1:0]         rd_adr_i,
  output logic [DATA_WIDTH-1:0] rd_dat_c_o
);

  typedef logic [DATA_WIDTH-1:0] mem_t [DEPTH_WORDS];

  function automatic mem_t init_pattern();
    mem_t m;
    for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
      m[i] = DATA_WIDTH'(i * 4);
    end
    return m;
  endfunction

  mem_t mem_q = init_pattern();

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wr_adr_i] <= wr_dat_i;
    end
  end

  assign rd_dat_c_o = mem_q[rd_adr_i];

endmodule

// File: rtl/cache_mem_responder.sv
// Behavioural main-memory responder: line refills and victim writebacks with a
// programmable access latency. Optional macro: CRITICAL_WORD_FIRST_EN.
module cache_mem_responder #(
  parameter int unsigned ADR_WIDTH       = cache_pkg::ADR_WIDTH,
  parameter int unsigned DATA_WIDTH      = cache_pkg::DATA_WIDTH,
  parameter int unsigned WORDS_PER_LINE  = cache_pkg::WORDS_PER_LINE,
  parameter int unsigned MEM_DEPTH_LINES = 256,
  parameter int unsigned LATENCY         = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          mem_req_i,
  input  logic                                          mem_we_i,
  input  logic [ADR_WIDTH-1:0]                          mem_adr_i,
  input  logic [DATA_WIDTH-1:0]                         mem_dat_i,
  output logic                                          mem_wready_o,
  output logic                                          mem_ack_o,
  output logic [DATA_WIDTH-1:0]                         mem_dat_o,
  output logic [cache_pkg::beat_w(WORDS_PER_LINE)-1:0]  mem_beat_o,
  output logic                                          mem_last_o,
  output logic                                          mem_busy_o
);

  import cache_pkg::*;

  localparam int unsigned BEAT_BITS = beat_w(WORDS_PER_LINE);
  localparam int unsigned LINE_BITS = beat_w(MEM_DEPTH_LINES);
  localparam int unsigned OFS_BITS  = BEAT_BITS + 2;
  localparam int unsigned WADR_BITS = LINE_BITS + BEAT_BITS;
  localparam int unsigned LAT_BITS  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(WORDS_PER_LINE - 1);
  localparam logic [LAT_BITS-1:0]  LAST_LAT  = LAT_BITS'(LATENCY - 1);

  state_e                 state_q, state_d;
  logic                   we_q, we_d;
  logic [LINE_BITS-1:0]   line_q, line_d;
  logic [BEAT_BITS-1:0]   start_q, start_d;
  logic [BEAT_BITS-1:0]   beat_q, beat_d;
  logic [LAT_BITS-1:0]    lat_q, lat_d;

  logic                   wready_q, wready_d;
  logic                   ack_q, ack_d;
  logic [DATA_WIDTH-1:0]  dat_q, dat_d;
  logic [BEAT_BITS-1:0]   obeat_q, obeat_d;
  logic                   last_q, last_d;
  logic                   busy_q, busy_d;

  logic                   emit_c;
  logic [BEAT_BITS-1:0]   rd_word_c;
  logic [WADR_BITS-1:0]   rd_adr_c;
  logic [WADR_BITS-1:0]   wr_adr_c;
  logic                   wr_en_c;
  logic [DATA_WIDTH-1:0]  rd_dat_c;
  logic                   unused_adr_c;

  // Only the line/word fields of the address matter; the rest alias away
  assign unused_adr_c = ^mem_adr_i;

  cache_mem_array #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH_WORDS (MEM_DEPTH_LINES * WORDS_PER_LINE),
    .AW          (WADR_BITS)
  ) u_array (
    .clk        (clk),
    .we_i       (wr_en_c),
    .wr_adr_i   (wr_adr_c),
    .wr_dat_i   (mem_dat_i),
    .rd_adr_i   (rd_adr_c),
    .rd_dat_c_o (rd_dat_c)
  );

  // Write beats land in the latched line, always starting at word 0
  assign wr_en_c  = (state_q == WBURST);
  assign wr_adr_c = {line_q, beat_q};

  // Next state, counters and the output values for the coming cycle
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    line_d   = line_q;
    start_d  = start_q;
    beat_d   = beat_q;
    lat_d    = lat_q;
    wready_d = 1'b0;
    ack_d    = 1'b0;
    last_d   = 1'b0;
    emit_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_req_i) begin
          we_d   = mem_we_i;
          line_d = mem_adr_i[OFS_BITS +: LINE_BITS];
`ifdef CRITICAL_WORD_FIRST_EN
          start_d = mem_adr_i[2 +: BEAT_BITS];
`else
          start_d = '0;
`endif
          beat_d = '0;
          lat_d  = '0;
          if (mem_we_i) begin
            state_d  = WBURST;
            wready_d = 1'b1;
          end else if (LATENCY == 0) begin
            state_d = RBURST;
            emit_c  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end

      WBURST: begin
        if (beat_q == LAST_BEAT) begin
          beat_d = '0;
          if (LATENCY == 0) begin
            state_d = WACK;
            ack_d   = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end else begin
          beat_d   = beat_q + BEAT_BITS'(1);
          wready_d = 1'b1;
        end
      end

      WAIT: begin
        if (lat_q == LAST_LAT) begin
          lat_d = '0;
          if (we_q) begin
            state_d = WACK;
            ack_d   = 1'b1;
          end else begin
            state_d = RBURST;
            emit_c  = 1'b1;
          end
        end else begin
          lat_d = lat_q + LAT_BITS'(1);
        end
      end

      RBURST: begin
        if (beat_q == LAST_BEAT) begin
          state_d = IDLE;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + BEAT_BITS'(1);
          emit_c = 1'b1;
        end
      end

      WACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (emit_c) begin
      ack_d  = 1'b1;
      last_d = (beat_d == LAST_BEAT);
    end
    busy_d = (state_d != IDLE);
  end

  // Read beat n fetches word (start + n) mod WORDS_PER_LINE
  assign rd_word_c = start_d + beat_d;
  assign rd_adr_c  = {line_d, rd_word_c};
  assign dat_d     = emit_c ? rd_dat_c : '0;
  assign obeat_d   = emit_c ? rd_word_c : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      line_q   <= '0;
      start_q  <= '0;
      beat_q   <= '0;
      lat_q    <= '0;
      wready_q <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      obeat_q  <= '0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      line_q   <= line_d;
      start_q  <= start_d;
      beat_q   <= beat_d;
      lat_q    <= lat_d;
      wready_q <= wready_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      obeat_q  <= obeat_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
    end
  end

  assign mem_wready_o = wready_q;
  assign mem_ack_o    = ack_q;
  assign mem_dat_o    = dat_q;
  assign mem_beat_o   = obeat_q;
  assign mem_last_o   = last_q;
  assign mem_busy_o   = busy_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Scoreboard bench for cache_mem_responder: one LATENCY=4 instance and one LATENCY=0 instance.
module tb_cache_mem_responder;

  localparam int unsigned LAT  = 4;
  localparam int unsigned WPL  = cache_pkg::WORDS_PER_LINE;
  localparam int unsigned BW   = cache_pkg::BEAT_W;
  localparam int unsigned LOFS = cache_pkg::LINE_OFS_W;

  typedef struct {
    logic [31:0]   dat;
    logic [BW-1:0] beat;
    logic          last;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;

  logic          req = 1'b0, we = 1'b0;
  logic [31:0]   adr = '0, wdat = '0;
  logic          wready, ack, last, busy;
  logic [31:0]   rdat;
  logic [BW-1:0] beat;

  logic          req0 = 1'b0, we0 = 1'b0;
  logic [31:0]   adr0 = '0, wdat0 = '0;
  logic          wready0, ack0, last0, busy0;
  logic [31:0]   rdat0;
  logic [BW-1:0] beat0;

  exp_t          sb[$];
  logic [31:0]   model [1024];
  int            n_chk = 0;
  int            n_pass = 0;

  always #5 clk = ~clk;

  cache_mem_responder #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .mem_req_i(req), .mem_we_i(we), .mem_adr_i(adr),
    .mem_dat_i(wdat), .mem_wready_o(wready), .mem_ack_o(ack), .mem_dat_o(rdat),
    .mem_beat_o(beat), .mem_last_o(last), .mem_busy_o(busy)
  );

  cache_mem_responder #(.LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .mem_req_i(req0), .mem_we_i(we0), .mem_adr_i(adr0),
    .mem_dat_i(wdat0), .mem_wready_o(wready0), .mem_ack_o(ack0), .mem_dat_o(rdat0),
    .mem_beat_o(beat0), .mem_last_o(last0), .mem_busy_o(busy0)
  );

  function automatic int line_of(input logic [31:0] a);
    return int'(a[LOFS +: 8]);
  endfunction

  function automatic int start_word(input logic [31:0] a);
`ifdef CRITICAL_WORD_FIRST_EN
    return int'(a[2 +: BW]);
`else
    return int'(a[2 +: BW]) * 0;
`endif
  endfunction

  // Read a line from the LATENCY=4 instance and score every beat
  task automatic test_read(input string nm, input logic [31:0] a);
    int   ln, w0, c, idx;
    exp_t e;
    ln = line_of(a);
    w0 = start_word(a);
    for (int n = 0; n < int'(WPL); n++) begin
      idx    = (w0 + n) % int'(WPL);
      e.dat  = model[ln * int'(WPL) + idx];
      e.beat = BW'(idx);
      e.last = (n == int'(WPL) - 1);
      e.cyc  = int'(LAT) + 1 + n;
      sb.push_back(e);
    end
    req = 1'b1; we = 1'b0; adr = a;
    c = 0;
    while (sb.size() > 0 && c < 30) begin
      @(posedge clk); #1; c++;
      if (c == 1) req = 1'b0;
      if (ack) begin
        e = sb.pop_front();
        n_chk++;
        if ({rdat, beat, last} !== {e.dat, e.beat, e.last} || c != e.cyc)
          $display("FAIL %s beat: got dat=%h beat=%0d last=%b cyc=%0d, exp dat=%h beat=%0d last=%b cyc=%0d",
                   nm, rdat, beat, last, c, e.dat, e.beat, e.last, e.cyc);
        else n_pass++;
      end
    end
    n_chk++;
    if (sb.size() != 0) begin
      $display("FAIL %s timeout: %0d beats missing, exp 0", nm, sb.size());
      sb.delete();
    end else n_pass++;
    @(posedge clk); #1;
    n_chk++;
    if ({busy, ack, last} !== 3'b000)
      $display("FAIL %s idle after burst: got busy=%b ack=%b last=%b, exp 0 0 0", nm, busy, ack, last);
    else n_pass++;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({wready, ack, rdat, beat, last, busy, wready0, ack0, rdat0, beat0, last0, busy0} !== '0)
      $display("FAIL reset_outputs: got %h/%h, exp all 0",
               {wready, ack, rdat, beat, last, busy}, {wready0, ack0, rdat0, beat0, last0, busy0});
    else n_pass++;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({busy, ack, busy0, ack0} !== 4'b0000)
      $display("FAIL reset_release_idle: got busy=%b ack=%b busy0=%b ack0=%b, exp 0", busy, ack, busy0, ack0);
    else n_pass++;
  endtask

  task automatic test_refill();
    n_chk++;
    if (model[line_of(32'h00CC3B40) * int'(WPL)] !== 32'h0000_0B40)
      $display("FAIL refill_init_word: got %h exp 00000b40", model[line_of(32'h00CC3B40) * int'(WPL)]);
    else n_pass++;
    test_read("refill", 32'h00CC3B40);
  endtask

  task automatic test_critical_word();
    test_read("critical_word", 32'h00CC3B48);
  endtask

  task automatic test_writeback(input string nm, input logic [31:0] a, input logic [31:0] d [4]);
    int c, k, ln;
    bit got_ack;
    ln = line_of(a);
    req = 1'b1; we = 1'b1; adr = a;
    c = 0; k = 0; got_ack = 1'b0;
    while (!got_ack && c < 30) begin
      @(posedge clk); #1; c++;
      if (c == 1) begin req = 1'b0; we = 1'b0; end
      if (wready) begin
        n_chk++;
        if (c != k + 1 || k >= int'(WPL))
          $display("FAIL %s wready: got cycle %0d beat %0d, exp cycle %0d", nm, c, k, k + 1);
        else n_pass++;
        if (k < int'(WPL)) begin
          wdat = d[k];
          model[ln * int'(WPL) + k] = d[k];
          k++;
        end
      end
      if (ack) begin
        got_ack = 1'b1;
        n_chk++;
        if (c != int'(WPL + LAT) + 1 || k != int'(WPL))
          $display("FAIL %s ack: got cycle %0d beats %0d, exp cycle %0d beats %0d",
                   nm, c, k, WPL + LAT + 1, WPL);
        else n_pass++;
      end
    end
    n_chk++;
    if (!got_ack) $display("FAIL %s timeout: no write ack after %0d cycles, exp ack", nm, c);
    else n_pass++;
    @(posedge clk); #1;
    n_chk++;
    if ({busy, ack, wready} !== 3'b000)
      $display("FAIL %s idle after ack: got busy=%b ack=%b wready=%b, exp 0", nm, busy, ack, wready);
    else n_pass++;
  endtask

  task automatic test_writeback_refill();
    logic [31:0] d [4];
    d = '{32'hEA99A94A, 32'h1, 32'h2, 32'h3};
    test_writeback("writeback", 32'h00CC3B40, d);
    test_read("alias_other_line", 32'h00CE0340);
    test_read("alias_written_line", 32'h00003B40);
  endtask

  // LATENCY=0: req held through the last beat is taken again only once idle
  task automatic test_back_to_back();
    int   c;
    exp_t e;
    for (int r = 0; r < 2; r++) begin
      for (int n = 0; n < int'(WPL); n++) begin
        e.dat  = 32'((32'h12 * WPL + n) * 4);
        e.beat = BW'(n);
        e.last = (n == int'(WPL) - 1);
        e.cyc  = 1 + n + r * (int'(WPL) + 1);
        sb.push_back(e);
      end
    end
    req0 = 1'b1; adr0 = 32'h0000_0120;
    c = 0;
    while (sb.size() > 0 && c < 30) begin
      @(posedge clk); #1; c++;
      if (c == int'(WPL) + 1) begin
        n_chk++;
        if ({busy0, ack0} !== 2'b00)
          $display("FAIL b2b_idle_gap: got busy=%b ack=%b in cycle %0d, exp 0 0", busy0, ack0, c);
        else n_pass++;
      end
      if (c == int'(WPL) + 2) req0 = 1'b0;
      if (ack0) begin
        e = sb.pop_front();
        n_chk++;
        if ({rdat0, beat0, last0} !== {e.dat, e.beat, e.last} || c != e.cyc)
          $display("FAIL b2b beat: got dat=%h beat=%0d last=%b cyc=%0d, exp dat=%h beat=%0d last=%b cyc=%0d",
                   rdat0, beat0, last0, c, e.dat, e.beat, e.last, e.cyc);
        else n_pass++;
      end
    end
    n_chk++;
    if (sb.size() != 0) begin
      $display("FAIL b2b timeout: %0d beats missing, exp 0", sb.size());
      sb.delete();
    end else n_pass++;
    @(posedge clk); #1;
    n_chk++;
    if ({busy0, ack0} !== 2'b00)
      $display("FAIL b2b_end_idle: got busy=%b ack=%b, exp 0 0", busy0, ack0);
    else n_pass++;
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] a;
    logic [31:0] d [4];
    int c, k, ln;
    bit seen;
    a  = 32'h00CC3B80;
    d  = '{32'hA5A50000, 32'hA5A50001, 32'hA5A50002, 32'hA5A50003};
    ln = line_of(a);
    req = 1'b1; we = 1'b1; adr = a;
    c = 0; k = 0; seen = 1'b0;
    while (!seen && c < 30) begin
      @(posedge clk); #1; c++;
      if (c == 1) begin req = 1'b0; we = 1'b0; end
      if (wready) begin
        wdat = d[k];
        if (k < 2) begin
          model[ln * int'(WPL) + k] = d[k];
          k++;
        end else begin
          #2 rst = 1'b0;
          #1 seen = 1'b1;
          n_chk++;
          if ({wready, ack, rdat, beat, last, busy} !== '0)
            $display("FAIL rst_mid_write_outputs: got %h, exp 0", {wready, ack, rdat, beat, last, busy});
          else n_pass++;
        end
      end
    end
    n_chk++;
    if (!seen) $display("FAIL rst_mid_write timeout: third beat not reached in %0d cycles", c);
    else n_pass++;
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ack || busy || wready) seen = 1'b1;
    end
    rst = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack || busy || wready) seen = 1'b1;
    end
    n_chk++;
    if (seen) $display("FAIL rst_mid_write_no_ack: got activity after abort, exp none");
    else n_pass++;
    test_read("read_after_abort", a);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) model[i] = 32'(i * 4);
    test_reset();
    test_refill();
    test_critical_word();
    test_writeback_refill();
    test_back_to_back();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, exp completion");
    $fatal(1);
  end

endmodule
